// File: rtl/led_sequencer.sv
// LED pattern controller: turns timer overflow ticks into count / scan / blink
// patterns, with button-driven mode advance and pause.
module led_sequencer #(
  parameter int LED_W     = 6,
  parameter int BLINK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             mode_next,
  input  logic             pause_toggle,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             paused,
  output logic             timer_restart
);

  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    M_COUNT   = 2'd0,
    M_SCAN    = 2'd1,
    M_BLINK   = 2'd2,
    M_ILLEGAL = 2'd3
  } mode_e;

  mode_e            mode_q,    mode_d;
  logic [LED_W-1:0] led_q,     led_d;
  logic             paused_q,  paused_d;
  logic             restart_q, restart_d;
  logic             dir_q,     dir_d;     // 0 = shifting up, 1 = shifting down
  logic [CNT_W-1:0] bcnt_q,    bcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= M_COUNT;
      led_q     <= '0;
      paused_q  <= 1'b0;
      restart_q <= 1'b0;
      dir_q     <= 1'b0;
      bcnt_q    <= '0;
    end else begin
      mode_q    <= mode_d;
      led_q     <= led_d;
      paused_q  <= paused_d;
      restart_q <= restart_d;
      dir_q     <= dir_d;
      bcnt_q    <= bcnt_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    led_d     = led_q;
    paused_d  = paused_q;
    restart_d = 1'b0;
    dir_d     = dir_q;
    bcnt_d    = bcnt_q;

    if (mode_q == M_ILLEGAL) begin
      // Unreachable encoding: recover into COUNT as if freshly entered.
      mode_d    = M_COUNT;
      led_d     = '0;
      paused_d  = 1'b0;
      restart_d = 1'b1;
      dir_d     = 1'b0;
      bcnt_d    = '0;
    end else if (mode_next) begin
      paused_d  = 1'b0;
      restart_d = 1'b1;
      dir_d     = 1'b0;
      bcnt_d    = '0;
      led_d     = '0;
      case (mode_q)
        M_COUNT: begin
          mode_d = M_SCAN;
          led_d  = LED_W'(1);
        end
        M_SCAN:  mode_d = M_BLINK;
        default: mode_d = M_COUNT;
      endcase
    end else if (pause_toggle) begin
      paused_d = ~paused_q;
    end else if (tick && !paused_q) begin
      case (mode_q)
        M_COUNT: led_d = led_q + LED_W'(1);
        M_SCAN: begin
          // Direction flips on the tick that lands on an end bit.
          if (!dir_q) begin
            led_d = led_q << 1;
            if (led_q[LED_W-2]) dir_d = 1'b1;
          end else begin
            led_d = led_q >> 1;
            if (led_q[1]) dir_d = 1'b0;
          end
        end
        M_BLINK: begin
          if (bcnt_q == BLINK_LAST) begin
            led_d  = ~led_q;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign led           = led_q;
  assign mode          = mode_q;
  assign paused        = paused_q;
  assign timer_restart = restart_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: a reference model pushes the expected
// outputs for each driven cycle; they are popped and compared after the edge.
module tb_led_sequencer;

  localparam int LED_W     = 6;
  localparam int BLINK_DIV = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             tick = 1'b0;
  logic             mode_next = 1'b0;
  logic             pause_toggle = 1'b0;
  logic [LED_W-1:0] led;
  logic [1:0]       mode;
  logic             paused;
  logic             timer_restart;

  led_sequencer #(.LED_W(LED_W), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_next(mode_next),
    .pause_toggle(pause_toggle), .led(led), .mode(mode), .paused(paused),
    .timer_restart(timer_restart)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LED_W-1:0] led;
    logic [1:0]       mode;
    logic             paused;
    logic             restart;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_bad = 0;

  // reference model state: scan tracked as a bit position
  logic [LED_W-1:0] m_led = '0;
  logic [1:0]       m_mode = 2'd0;
  logic             m_paused = 1'b0;
  logic             m_restart = 1'b0;
  int               m_pos = 0;
  logic             m_down = 1'b0;
  int               m_bcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic t, input logic mn, input logic pt);
    m_restart = 1'b0;
    if (r) begin
      m_led = '0; m_mode = 2'd0; m_paused = 1'b0; m_pos = 0; m_down = 1'b0; m_bcnt = 0;
    end else if (mn) begin
      m_mode    = (m_mode == 2'd2) ? 2'd0 : m_mode + 2'd1;
      m_paused  = 1'b0;
      m_restart = 1'b1;
      m_pos = 0; m_down = 1'b0; m_bcnt = 0;
      m_led = (m_mode == 2'd1) ? LED_W'(1) : '0;
    end else if (pt) begin
      m_paused = ~m_paused;
    end else if (t && !m_paused) begin
      case (m_mode)
        2'd0: m_led = LED_W'((int'(m_led) + 1) % (1 << LED_W));
        2'd1: begin
          m_pos = m_down ? m_pos - 1 : m_pos + 1;
          if (m_pos == LED_W - 1) m_down = 1'b1;
          if (m_pos == 0) m_down = 1'b0;
          m_led = LED_W'(1 << m_pos);
        end
        default: begin
          m_bcnt++;
          if (m_bcnt == BLINK_DIV) begin
            m_bcnt = 0;
            m_led  = ~m_led;
          end
        end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic t, input logic mn, input logic pt);
    exp_t e;
    @(negedge clk);
    rst = r; tick = t; mode_next = mn; pause_toggle = pt;
    model(r, t, mn, pt);
    e.led = m_led; e.mode = m_mode; e.paused = m_paused; e.restart = m_restart;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("led",     32'(led),           32'(e.led));
    chk("mode",    32'(mode),          32'(e.mode));
    chk("paused",  32'(paused),        32'(e.paused));
    chk("restart", 32'(timer_restart), 32'(e.restart));
  endtask

  initial begin
    int scan_tbl[13] = '{1, 2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2, 4};
    int blink_tbl[7] = '{'h0, 'h0, 'h3F, 'h3F, 'h0, 'h0, 'h3F};

    // 1: reset (with noise on other inputs), then 70 ticks in COUNT
    step(1, 1, 1, 1);
    step(1, 0, 0, 0);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    for (int i = 1; i <= 70; i++) begin
      step(0, 1, 0, 0);
      if (i == 63) chk("cnt_max", 32'(led), 32'd63);
      if (i == 64) chk("cnt_wrap", 32'(led), 32'd0);
    end
    chk("cnt_70", 32'(led), 32'd6);

    // 2: SCAN entry and bounce
    step(0, 0, 1, 0);
    chk("scan_restart", 32'(timer_restart), 32'd1);
    chk("scan_mode", 32'(mode), 32'd1);
    chk("scan_0", 32'(led), 32'(scan_tbl[0]));
    step(0, 0, 0, 0);
    chk("restart_pulse", 32'(timer_restart), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 0, 0);
      chk("scan_seq", 32'(led), 32'(scan_tbl[i]));
    end

    // 3: BLINK
    step(0, 0, 1, 0);
    chk("blink_0", 32'(led), 32'(blink_tbl[0]));
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 0, 0);
      chk("blink_seq", 32'(led), 32'(blink_tbl[i]));
    end

    // 4: pause in COUNT at led=5
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    chk("pre_pause", 32'(led), 32'd5);
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("paused_hold", 32'(led), 32'd5);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    chk("resume", 32'(led), 32'd6);

    // pause_toggle beats tick; leave paused so the next test clears it
    step(0, 1, 0, 1);
    chk("pt_over_tick", 32'(led), 32'd6);

    // 5: mode_next + pause_toggle + tick together
    step(0, 1, 1, 1);
    chk("mn_mode", 32'(mode), 32'd1);
    chk("mn_paused", 32'(paused), 32'd0);
    chk("mn_led", 32'(led), 32'd1);
    chk("mn_restart", 32'(timer_restart), 32'd1);

    // 6: reset mid-SCAN at led=16 with tick high
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("pre_rst", 32'(led), 32'd16);
    step(1, 1, 0, 0);
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_restart", 32'(timer_restart), 32'd0);

    // back-to-back mode_next
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("b2b_mode", 32'(mode), 32'd0);
    chk("b2b_restart", 32'(timer_restart), 32'd1);

    // random mix, rare mode/pause/reset events
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 6));

    @(negedge clk);
    rst = 0; tick = 0; mode_next = 0; pause_toggle = 0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
